// File: rtl/midi_parser.sv
// MIDI channel-voice parser: status/running-status tracking, channel filter, registered message outputs.
// Build option: define MIDI_PARSER_RUNNING_STATUS_EN to keep the status latched after each message.
module midi_parser #(
  parameter int Channel = 0,
  parameter bit Omni    = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ready,
  input  logic [7:0] i_data_byte,
  output logic       o_valid,
  output logic [1:0] o_msg_type,
  output logic [3:0] o_channel,
  output logic [6:0] o_data1,
  output logic [6:0] o_data2
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;

  localparam logic [3:0] ChanSel = 4'(Channel);

  state_t     state_q, state_d;
  logic [3:0] stype_q, stype_d;
  logic [3:0] schan_q, schan_d;
  logic [6:0] data1_q, data1_d;
  logic       valid_q, valid_d;
  logic [1:0] type_q, type_d;
  logic [3:0] chan_q, chan_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] d2_q, d2_d;

  logic       one_byte_msg;
  logic       emit_type;
  logic       chan_ok;
  state_t     after_msg;

  always_comb begin
    one_byte_msg = (stype_q == 4'hC) || (stype_q == 4'hD);
    emit_type    = (stype_q == 4'h8) || (stype_q == 4'h9) ||
                   (stype_q == 4'hB) || (stype_q == 4'hE);
    chan_ok      = Omni || (schan_q == ChanSel);
`ifdef MIDI_PARSER_RUNNING_STATUS_EN
    after_msg    = DATA1;
`else
    after_msg    = IDLE;
`endif
  end

  always_comb begin
    state_d = state_q;
    stype_d = stype_q;
    schan_d = schan_q;
    data1_d = data1_q;
    valid_d = 1'b0;
    type_d  = type_q;
    chan_d  = chan_q;
    d1_d    = d1_q;
    d2_d    = d2_q;

    if (i_ready) begin
      if (i_data_byte >= 8'hF8) begin
        state_d = state_q;
      end else if (i_data_byte >= 8'hF0) begin
        state_d = IDLE;
      end else if (i_data_byte[7]) begin
        stype_d = i_data_byte[7:4];
        schan_d = i_data_byte[3:0];
        data1_d = 7'd0;
        state_d = DATA1;
      end else begin
        case (state_q)
          DATA1: begin
            data1_d = i_data_byte[6:0];
            state_d = one_byte_msg ? after_msg : DATA2;
          end
          DATA2: begin
            state_d = after_msg;
            // Filtered or non-emitted messages still complete here to keep byte alignment.
            if (emit_type && chan_ok) begin
              valid_d = 1'b1;
              chan_d  = schan_q;
              d1_d    = data1_q;
              d2_d    = i_data_byte[6:0];
              case (stype_q)
                4'h8:    type_d = 2'd0;
                4'h9:    type_d = (i_data_byte[6:0] == 7'd0) ? 2'd0 : 2'd1;
                4'hB:    type_d = 2'd2;
                default: type_d = 2'd3;
              endcase
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      stype_q <= 4'd0;
      schan_q <= 4'd0;
      data1_q <= 7'd0;
      valid_q <= 1'b0;
      type_q  <= 2'd0;
      chan_q  <= 4'd0;
      d1_q    <= 7'd0;
      d2_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      stype_q <= stype_d;
      schan_q <= schan_d;
      data1_q <= data1_d;
      valid_q <= valid_d;
      type_q  <= type_d;
      chan_q  <= chan_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_msg_type = type_q;
  assign o_channel  = chan_q;
  assign o_data1    = d1_q;
  assign o_data2    = d2_q;

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: channel-0 filtered instance and an Omni instance against a byte-level message model.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [7:0] dat;

  logic       c_vld, o_vld;
  logic [1:0] c_type, o_type;
  logic [3:0] c_ch, o_ch;
  logic [6:0] c_d1, c_d2, o_d1, o_d2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  midi_parser #(.Channel(0), .Omni(1'b0)) u_ch (
    .i_clk(clk), .i_rst(rst), .i_ready(rdy), .i_data_byte(dat),
    .o_valid(c_vld), .o_msg_type(c_type), .o_channel(c_ch),
    .o_data1(c_d1), .o_data2(c_d2)
  );

  midi_parser #(.Channel(0), .Omni(1'b1)) u_omni (
    .i_clk(clk), .i_rst(rst), .i_ready(rdy), .i_data_byte(dat),
    .o_valid(o_vld), .o_msg_type(o_type), .o_channel(o_ch),
    .o_data1(o_d1), .o_data2(o_d2)
  );

  // Model: current status byte (0 = none), count of data bytes collected, first data byte.
  logic [7:0]  m_status;
  int          m_cnt;
  logic [6:0]  m_d1;
  bit          exp_vld [2];
  logic [20:0] exp_out [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int         need;
    logic [3:0] hi;
    logic [1:0] t;
    if (b >= 8'hF8) begin
      need = 0;
    end else if (b >= 8'hF0) begin
      m_status = 8'h00;
    end else if (b[7]) begin
      m_status = b;
      m_cnt    = 0;
    end else if (m_status != 8'h00) begin
      hi   = m_status[7:4];
      need = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
      if (m_cnt == 0) m_d1 = b[6:0];
      m_cnt++;
      if (m_cnt == need) begin
        if (need == 2 && hi != 4'hA) begin
          if (hi == 4'h8) t = 2'd0;
          else if (hi == 4'h9) t = (b[6:0] == 7'd0) ? 2'd0 : 2'd1;
          else if (hi == 4'hB) t = 2'd2;
          else t = 2'd3;
          for (int k = 0; k < 2; k++) begin
            if (k == 1 || m_status[3:0] == 4'd0) begin
              exp_vld[k] = 1'b1;
              exp_out[k] = {t, m_status[3:0], m_d1, b[6:0]};
            end
          end
        end
        m_cnt = 0;
`ifndef MIDI_PARSER_RUNNING_STATUS_EN
        m_status = 8'h00;
`endif
      end
    end
  endtask

  task automatic cycle(input bit r, input bit rd, input logic [7:0] b);
    rst = r;
    rdy = rd;
    dat = b;
    exp_vld[0] = 1'b0;
    exp_vld[1] = 1'b0;
    if (r) begin
      m_status   = 8'h00;
      m_cnt      = 0;
      exp_out[0] = '0;
      exp_out[1] = '0;
    end else if (rd) begin
      model_byte(b);
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("ch_vld",   32'(c_vld), 32'(exp_vld[0]));
    check_eq("ch_out",   32'({c_type, c_ch, c_d1, c_d2}), 32'(exp_out[0]));
    check_eq("omni_vld", 32'(o_vld), 32'(exp_vld[1]));
    check_eq("omni_out", 32'({o_type, o_ch, o_d1, o_d2}), 32'(exp_out[1]));
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b0, 1'b1, b);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    int         p;
    rst = 1'b1;
    rdy = 1'b0;
    dat = 8'h00;
    m_status = 8'h00;
    m_cnt = 0;
    m_d1 = 7'd0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 8'h90);
    check_eq("reset_state", 32'({c_vld, c_type, c_ch, c_d1, c_d2}), 32'd0);

    send(8'h90); send(8'h3C); send(8'h64);
    check_eq("note_on", 32'({c_vld, c_type, c_ch, c_d1, c_d2}),
             32'({1'b1, 2'd1, 4'd0, 7'h3C, 7'h64}));
    send(8'h40); send(8'h00);
    cycle(1'b0, 1'b0, 8'h55);
    check_eq("hold_after_msg", 32'({c_vld, c_type, c_ch, c_d1, c_d2}), 32'(exp_out[0]));
    send(8'hF0);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    send(8'h93); send(8'h3C); send(8'h64);
    check_eq("omni_ch3", 32'({o_vld, o_ch}), 32'({1'b1, 4'd3}));
    send(8'hC0); send(8'h05); send(8'hB0); send(8'h07); send(8'h7F);
    check_eq("cc", 32'({c_vld, c_type, c_d1, c_d2}), 32'({1'b1, 2'd2, 7'h07, 7'h7F}));
    send(8'h90); send(8'h3C);
    cycle(1'b1, 1'b0, 8'h00);
    send(8'h64);
    check_eq("rst_mid_msg", 32'({c_vld, c_type, c_ch, c_d1, c_d2}), 32'd0);
    send(8'hE0); send(8'h00); send(8'h40);
    check_eq("pitch_bend", 32'({c_vld, c_type, c_d1, c_d2}), 32'({1'b1, 2'd3, 7'h00, 7'h40}));
    send(8'hA0); send(8'h10); send(8'h20);
    send(8'hF2); send(8'h10); send(8'h20);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      end else if (r < 20) begin
        cycle(1'b0, 1'b0, 8'($urandom));
      end else begin
        p = $urandom_range(0, 99);
        if (p < 50) b = 8'($urandom_range(0, 127));
        else if (p < 80) begin
          b = 8'($urandom_range(8'h80, 8'hEF));
          if ($urandom_range(0, 1) == 1) b[3:0] = 4'd0;
        end
        else if (p < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
        else b = 8'($urandom_range(8'hF0, 8'hF7));
        send(b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
